// File: rtl/vend_credit_controller_if.sv
// rtl/vend_credit_controller_if.sv - coin/selection front end and dispense actuator bundle
interface vend_credit_controller_if;
  logic       n_in;
  logic       d_in;
  logic       q_in;
  logic       soda_in;
  logic       diet_in;
  logic       cancel_in;
  logic       disp_ready;
  logic       give_soda;
  logic       give_diet;
  logic       n_out;
  logic       d_out;
  logic       q_out;
  logic       coin_reject;
  logic       sel_deny;
  logic [6:0] credit;
  logic       busy;

  modport slave (
    input  n_in, d_in, q_in, soda_in, diet_in, cancel_in, disp_ready,
    output give_soda, give_diet, n_out, d_out, q_out, coin_reject, sel_deny, credit, busy
  );

  modport master (
    output n_in, d_in, q_in, soda_in, diet_in, cancel_in, disp_ready,
    input  give_soda, give_diet, n_out, d_out, q_out, coin_reject, sel_deny, credit, busy
  );
endinterface

// File: rtl/vend_credit_controller.sv
// rtl/vend_credit_controller.sv - credit accumulation, product vend and greedy change payout
module vend_credit_controller #(
  parameter int SODA_PRICE = 25,
  parameter int DIET_PRICE = 30,
  parameter int MAX_CREDIT = 100
) (
  input  logic                     clk,
  input  logic                     reset,
  vend_credit_controller_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, VEND, CHANGE} state_t;

  localparam logic [7:0] SODA = 8'(SODA_PRICE);
  localparam logic [7:0] DIET = 8'(DIET_PRICE);
  localparam logic [7:0] MAXC = 8'(MAX_CREDIT);

  state_t     state_q, state_d;
  logic [6:0] credit_q, credit_d;
  logic       give_soda_q, give_soda_d;
  logic       give_diet_q, give_diet_d;
  logic       n_out_q, n_out_d;
  logic       d_out_q, d_out_d;
  logic       q_out_q, q_out_d;
  logic       coin_reject_q, coin_reject_d;
  logic       sel_deny_q, sel_deny_d;

  logic [7:0] credit_w;
  logic [7:0] coin_val;
  logic [7:0] coin_add;
  logic [7:0] price;
  logic       coin_any;
  logic       coin_extra;
  logic       coin_fits;
  logic       sel_any;
  logic       sel_ok;

  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    give_soda_d   = 1'b0;
    give_diet_d   = 1'b0;
    n_out_d       = 1'b0;
    d_out_d       = 1'b0;
    q_out_d       = 1'b0;
    coin_reject_d = 1'b0;
    sel_deny_d    = 1'b0;
    coin_add      = 8'd0;

    credit_w = {1'b0, credit_q};
    if (bus.q_in)      coin_val = 8'd25;
    else if (bus.d_in) coin_val = 8'd10;
    else if (bus.n_in) coin_val = 8'd5;
    else               coin_val = 8'd0;
    coin_any   = bus.q_in | bus.d_in | bus.n_in;
    // Lower-priority coins arriving alongside a higher one are lost.
    coin_extra = (bus.q_in & (bus.d_in | bus.n_in)) | (bus.d_in & bus.n_in);
    coin_fits  = (credit_w + coin_val) <= MAXC;
    price      = bus.soda_in ? SODA : DIET;
    sel_any    = bus.soda_in | bus.diet_in;
    sel_ok     = sel_any && (price <= credit_w);

    case (state_q)
      IDLE: begin
        coin_reject_d = coin_extra | (coin_any & ~coin_fits);
        if (coin_fits) coin_add = coin_val;
        if (sel_ok) begin
          state_d     = VEND;
          credit_d    = 7'(credit_w - price + coin_add);
          give_soda_d = bus.soda_in;
          give_diet_d = ~bus.soda_in;
        end else begin
          sel_deny_d = sel_any;
          credit_d   = 7'(credit_w + coin_add);
          if (bus.cancel_in && credit_q != 7'd0) state_d = CHANGE;
        end
      end
      VEND: begin
        coin_reject_d = coin_any;
        state_d       = (credit_q != 7'd0) ? CHANGE : IDLE;
      end
      CHANGE: begin
        coin_reject_d = coin_any;
        if (credit_q == 7'd0) begin
          state_d = IDLE;
        end else if (bus.disp_ready) begin
          // Credit is always a multiple of 5, so a nickel always fits below a dime.
          if (credit_q >= 7'd25) begin
            q_out_d  = 1'b1;
            credit_d = credit_q - 7'd25;
          end else if (credit_q >= 7'd10) begin
            d_out_d  = 1'b1;
            credit_d = credit_q - 7'd10;
          end else begin
            n_out_d  = 1'b1;
            credit_d = credit_q - 7'd5;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      credit_q      <= 7'd0;
      give_soda_q   <= 1'b0;
      give_diet_q   <= 1'b0;
      n_out_q       <= 1'b0;
      d_out_q       <= 1'b0;
      q_out_q       <= 1'b0;
      coin_reject_q <= 1'b0;
      sel_deny_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      give_soda_q   <= give_soda_d;
      give_diet_q   <= give_diet_d;
      n_out_q       <= n_out_d;
      d_out_q       <= d_out_d;
      q_out_q       <= q_out_d;
      coin_reject_q <= coin_reject_d;
      sel_deny_q    <= sel_deny_d;
    end
  end

  assign bus.give_soda   = give_soda_q;
  assign bus.give_diet   = give_diet_q;
  assign bus.n_out       = n_out_q;
  assign bus.d_out       = d_out_q;
  assign bus.q_out       = q_out_q;
  assign bus.coin_reject = coin_reject_q;
  assign bus.sel_deny    = sel_deny_q;
  assign bus.credit      = credit_q;
  assign bus.busy        = (state_q != IDLE);

endmodule

// File: tb/tb_vend_credit_controller.sv
// tb/tb_vend_credit_controller.sv - directed bench for the vend credit controller
module tb_vend_credit_controller;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  vend_credit_controller_if vif();

  vend_credit_controller #(
    .SODA_PRICE(25),
    .DIET_PRICE(30),
    .MAX_CREDIT(100)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (vif.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear();
    vif.n_in = 0; vif.d_in = 0; vif.q_in = 0;
    vif.soda_in = 0; vif.diet_in = 0; vif.cancel_in = 0;
  endtask

  task automatic coin(input int cents);
    clear();
    if (cents == 25) vif.q_in = 1;
    else if (cents == 10) vif.d_in = 1;
    else vif.n_in = 1;
    tick();
    clear();
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (vif.busy && n < 50) begin
      tick();
      n++;
    end
    check(tag, vif.busy, 0);
  endtask

  function automatic logic [2:0] coins();
    return {vif.q_out, vif.d_out, vif.n_out};
  endfunction

  initial begin
    clear();
    vif.disp_ready = 1;
    vif.q_in = 1;
    tick();
    check("rst_credit", vif.credit, 0);
    check("rst_busy", vif.busy, 0);
    check("rst_reject", vif.coin_reject, 0);
    check("rst_give", {vif.give_soda, vif.give_diet}, 0);
    reset = 0;
    clear();
    tick();

    // single quarter buys soda exactly
    coin(25);
    check("t1_credit25", vif.credit, 25);
    vif.soda_in = 1; tick(); clear();
    check("t1_give", vif.give_soda, 1);
    check("t1_credit0", vif.credit, 0);
    check("t1_busy_vend", vif.busy, 1);
    tick();
    check("t1_give_off", vif.give_soda, 0);
    check("t1_idle", vif.busy, 0);
    check("t1_nocoins", coins(), 0);

    // soda with 35 -> dime change
    coin(25); coin(10);
    check("t2_credit35", vif.credit, 35);
    vif.soda_in = 1; tick(); clear();
    check("t2_give", vif.give_soda, 1);
    check("t2_credit10", vif.credit, 10);
    tick();
    check("t2_change_entry", coins(), 0);
    tick();
    check("t2_dime", coins(), 3'b010);
    check("t2_credit0", vif.credit, 0);
    tick();
    check("t2_nocoins", coins(), 0);
    check("t2_idle", vif.busy, 0);

    // cancel 40 -> q, d, n
    coin(25); coin(10); coin(5);
    check("t3_credit40", vif.credit, 40);
    vif.cancel_in = 1; tick(); clear();
    check("t3_busy", vif.busy, 1);
    check("t3_entry", coins(), 0);
    tick(); check("t3_q", coins(), 3'b100); check("t3_c15", vif.credit, 15);
    tick(); check("t3_d", coins(), 3'b010); check("t3_c5", vif.credit, 5);
    tick(); check("t3_n", coins(), 3'b001); check("t3_c0", vif.credit, 0);
    tick(); check("t3_idle", vif.busy, 0); check("t3_quiet", coins(), 0);

    // cancel 40 with dispenser stalls
    coin(25); coin(10); coin(5);
    vif.cancel_in = 1; tick(); clear();
    tick(); check("t4_q", coins(), 3'b100);
    vif.disp_ready = 0;
    for (int i = 0; i < 3; i++) begin
      tick(); check("t4_stall1", coins(), 0); check("t4_hold15", vif.credit, 15);
    end
    vif.disp_ready = 1;
    tick(); check("t4_d", coins(), 3'b010); check("t4_c5", vif.credit, 5);
    vif.disp_ready = 0;
    for (int i = 0; i < 3; i++) begin
      tick(); check("t4_stall2", coins(), 0); check("t4_hold5", vif.credit, 5);
    end
    vif.disp_ready = 1;
    tick(); check("t4_n", coins(), 3'b001); check("t4_c0", vif.credit, 0);
    tick(); check("t4_idle", vif.busy, 0);

    // credit ceiling
    coin(25); coin(25); coin(25); coin(10); coin(10);
    check("t5_credit95", vif.credit, 95);
    coin(25);
    check("t5_reject", vif.coin_reject, 1);
    check("t5_hold95", vif.credit, 95);
    coin(5);
    check("t5_reject_off", vif.coin_reject, 0);
    check("t5_credit100", vif.credit, 100);
    vif.cancel_in = 1; tick(); clear();
    drain("t5_drain");
    check("t5_drained", vif.credit, 0);

    // diet denied with 25
    coin(25);
    vif.diet_in = 1; tick(); clear();
    check("t5_deny", vif.sel_deny, 1);
    check("t5_nodiet", vif.give_diet, 0);
    check("t5_deny_credit", vif.credit, 25);
    check("t5_deny_idle", vif.busy, 0);
    tick();
    check("t5_deny_off", vif.sel_deny, 0);

    // quarter and dime together: quarter credited, one reject
    vif.q_in = 1; vif.d_in = 1; tick(); clear();
    check("t5_multi_credit", vif.credit, 50);
    check("t5_multi_reject", vif.coin_reject, 1);
    tick();
    check("t5_multi_off", vif.coin_reject, 0);

    // diet with 50 -> 20 change
    vif.diet_in = 1; tick(); clear();
    check("t6_give_diet", vif.give_diet, 1);
    check("t6_credit20", vif.credit, 20);
    drain("t6_drain");
    check("t6_drained", vif.credit, 0);

    // soda beats diet and cancel; coin in VEND rejected
    coin(25); coin(25);
    vif.soda_in = 1; vif.diet_in = 1; vif.cancel_in = 1; tick(); clear();
    check("t7_soda", vif.give_soda, 1);
    check("t7_nodiet", vif.give_diet, 0);
    check("t7_credit25", vif.credit, 25);
    vif.n_in = 1; tick(); clear();
    check("t7_vend_reject", vif.coin_reject, 1);
    check("t7_vend_hold", vif.credit, 25);
    drain("t7_drain");

    // reset mid-change
    coin(25); coin(5);
    vif.cancel_in = 1; tick(); clear();
    check("t8_change30", vif.credit, 30);
    check("t8_busy", vif.busy, 1);
    reset = 1; tick(); reset = 0;
    check("t8_rst_credit", vif.credit, 0);
    check("t8_rst_idle", vif.busy, 0);
    check("t8_rst_coins", coins(), 0);
    for (int i = 0; i < 3; i++) begin
      tick(); check("t8_quiet", coins(), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
